// File: rtl/spi_slave_pkg.sv
// Shared constants and helpers for the oversampled SPI slave and its FIFOs.
package spi_slave_pkg;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int SYNC_STAGES = 2;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read; DEPTH must be a power of two.
module sync_fifo
  import spi_slave_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst,
  input  logic                    wr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);
  // A pop frees the slot, so a push into a full FIFO is accepted in the same cycle.
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and level define what is valid.
  always_ff @(posedge i_sys_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_fifo.sv
// SPI slave, all four modes, with SCLK/SSN/MOSI oversampled in the i_sys_clk domain
// and TX/RX FIFOs carrying sticky underrun/overrun flags.
module spi_slave_fifo
  import spi_slave_pkg::*;
#(
  parameter int                  DATA_SIZE  = 8,
  parameter int                  FIFO_DEPTH = 16,
  parameter logic [DATA_SIZE-1:0] IDLE_WORD = '1
) (
  input  logic                         i_sys_clk,
  input  logic                         i_sys_rst,
  input  logic                         i_cpol,
  input  logic                         i_cpha,
  input  logic                         i_lsb_first,
  input  logic                         i_sclk,
  input  logic                         i_ssn,
  input  logic                         i_mosi,
  output logic                         o_miso,
  output logic                         o_miso_oe,
  input  logic [DATA_SIZE-1:0]         i_tx_data,
  input  logic                         i_tx_wr,
  output logic                         o_tx_full,
  output logic [clog2(FIFO_DEPTH):0]   o_tx_level,
  output logic [DATA_SIZE-1:0]         o_rx_data,
  input  logic                         i_rx_rd,
  output logic                         o_rx_empty,
  output logic [clog2(FIFO_DEPTH):0]   o_rx_level,
  output logic                         o_word_done,
  output logic                         o_rx_overrun,
  output logic                         o_tx_underrun,
  input  logic                         i_clr_err
);

  localparam int CW = clog2(DATA_SIZE);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_SIZE - 1);

  logic [SYNC_STAGES:0]   sclk_sync, ssn_sync;
  logic [SYNC_STAGES-1:0] mosi_sync, sync_fill;
  logic sclk_s, sclk_d, ssn_s, ssn_d, mosi_s;
  logic armed, cpol_q, cpha_q, lsb_q, load_d, miso_q;
  logic selected, ssn_fall, sclk_rise, sclk_fall;
  logic sample_edge, shift_edge, completion, load, shift_now;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_SIZE-1:0] rx_shift, rx_next, tx_shift, tx_rest, tx_fifo_head;
  logic tx_head, tx_empty, rx_full;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      sclk_sync <= '0;
      ssn_sync  <= '1;
      mosi_sync <= '0;
      sync_fill <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], i_sclk};
      ssn_sync  <= {ssn_sync[SYNC_STAGES-1:0], i_ssn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign sclk_d = sclk_sync[SYNC_STAGES];
  assign ssn_s  = ssn_sync[SYNC_STAGES-1];
  assign ssn_d  = ssn_sync[SYNC_STAGES];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // The bus is only trusted once a real (not reset-preset) SSN high has been seen.
  assign selected  = armed & ~ssn_s;
  assign ssn_fall  = armed & ssn_d & ~ssn_s;
  assign sclk_rise = selected & sclk_s & ~sclk_d;
  assign sclk_fall = selected & ~sclk_s & sclk_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sample_edge = 1'b0;
    shift_edge  = 1'b0;
    case ({cpol_q, cpha_q})
      MODE0: begin sample_edge = sclk_rise; shift_edge = sclk_fall; end
      MODE1: begin sample_edge = sclk_fall; shift_edge = sclk_rise; end
      MODE2: begin sample_edge = sclk_fall; shift_edge = sclk_rise; end
      MODE3: begin sample_edge = sclk_rise; shift_edge = sclk_fall; end
      default: ;
    endcase
  end

  assign completion = sample_edge & (bit_cnt == LAST_BIT);
  assign load       = ssn_fall | completion;
  // With CPHA=0 the trailing edge right after a word's last sample must not
  // disturb the next word's first bit, already driven after the load.
  assign shift_now  = shift_edge & (cpha_q | (bit_cnt != '0));
  assign rx_next    = lsb_q ? {mosi_s, rx_shift[DATA_SIZE-1:1]} : {rx_shift[DATA_SIZE-2:0], mosi_s};
  assign tx_head    = lsb_q ? tx_shift[0] : tx_shift[DATA_SIZE-1];
  assign tx_rest    = lsb_q ? (tx_shift >> 1) : (tx_shift << 1);

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      armed         <= 1'b0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      lsb_q         <= 1'b0;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      miso_q        <= 1'b0;
      load_d        <= 1'b0;
      o_word_done   <= 1'b0;
      o_rx_overrun  <= 1'b0;
      o_tx_underrun <= 1'b0;
    end else begin
      armed       <= armed | (sync_fill[SYNC_STAGES-1] & ssn_s);
      load_d      <= load;
      o_word_done <= completion;
      if (!selected) begin
        cpol_q   <= i_cpol;
        cpha_q   <= i_cpha;
        lsb_q    <= i_lsb_first;
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
        miso_q   <= 1'b0;
      end else begin
        if (sample_edge) begin
          bit_cnt  <= completion ? '0 : bit_cnt + 1'b1;
          rx_shift <= rx_next;
        end
        if (load) begin
          tx_shift <= tx_empty ? IDLE_WORD : tx_fifo_head;
        end else if ((load_d & ~cpha_q) | shift_now) begin
          miso_q   <= tx_head;
          tx_shift <= tx_rest;
        end
      end
      o_tx_underrun <= (load & tx_empty) | (o_tx_underrun & ~i_clr_err);
      o_rx_overrun  <= (completion & rx_full & ~i_rx_rd) | (o_rx_overrun & ~i_clr_err);
    end
  end

  assign o_miso    = selected & miso_q;
  assign o_miso_oe = selected;

  sync_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_sys_clk (i_sys_clk),
    .i_sys_rst (i_sys_rst),
    .wr        (i_tx_wr),
    .wr_data   (i_tx_data),
    .rd        (load),
    .rd_data   (tx_fifo_head),
    .full      (o_tx_full),
    .empty     (tx_empty),
    .level     (o_tx_level)
  );

  sync_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_sys_clk (i_sys_clk),
    .i_sys_rst (i_sys_rst),
    .wr        (completion),
    .wr_data   (rx_next),
    .rd        (i_rx_rd),
    .rd_data   (o_rx_data),
    .full      (rx_full),
    .empty     (o_rx_empty),
    .level     (o_rx_level)
  );

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Directed bench for spi_slave_fifo (DATA_SIZE=8, FIFO_DEPTH=4) with an RX scoreboard queue.
module tb_spi_slave_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int LW = 3;

  logic          i_sys_clk = 1'b0;
  logic          i_sys_rst, i_cpol, i_cpha, i_lsb_first, i_sclk, i_ssn, i_mosi;
  logic          o_miso, o_miso_oe, i_tx_wr, o_tx_full, i_rx_rd, o_rx_empty;
  logic          o_word_done, o_rx_overrun, o_tx_underrun, i_clr_err;
  logic [DW-1:0] i_tx_data, o_rx_data;
  logic [LW-1:0] o_tx_level, o_rx_level;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int base;
  bit m_cpha, m_lsb;
  logic [7:0] exp_rx[$];

  always #5 i_sys_clk = ~i_sys_clk;

  spi_slave_fifo #(.DATA_SIZE(DW), .FIFO_DEPTH(DEPTH)) dut (
    .i_sys_clk(i_sys_clk), .i_sys_rst(i_sys_rst), .i_cpol(i_cpol), .i_cpha(i_cpha),
    .i_lsb_first(i_lsb_first), .i_sclk(i_sclk), .i_ssn(i_ssn), .i_mosi(i_mosi),
    .o_miso(o_miso), .o_miso_oe(o_miso_oe), .i_tx_data(i_tx_data), .i_tx_wr(i_tx_wr),
    .o_tx_full(o_tx_full), .o_tx_level(o_tx_level), .o_rx_data(o_rx_data), .i_rx_rd(i_rx_rd),
    .o_rx_empty(o_rx_empty), .o_rx_level(o_rx_level), .o_word_done(o_word_done),
    .o_rx_overrun(o_rx_overrun), .o_tx_underrun(o_tx_underrun), .i_clr_err(i_clr_err)
  );

  always @(posedge i_sys_clk) if (o_word_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge i_sys_clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_miso"}, o_miso, 0);
    check({tag, "_oe"}, o_miso_oe, 0);
    check({tag, "_tx_full"}, o_tx_full, 0);
    check({tag, "_tx_level"}, o_tx_level, 0);
    check({tag, "_rx_data"}, o_rx_data, 0);
    check({tag, "_rx_empty"}, o_rx_empty, 1);
    check({tag, "_rx_level"}, o_rx_level, 0);
    check({tag, "_word_done"}, o_word_done, 0);
    check({tag, "_overrun"}, o_rx_overrun, 0);
    check({tag, "_underrun"}, o_tx_underrun, 0);
  endtask

  task automatic tx_push(input logic [7:0] d);
    i_tx_data = d;
    i_tx_wr = 1'b1;
    wait_cyc(1);
    i_tx_wr = 1'b0;
  endtask

  task automatic rx_pop_check(input string tag);
    logic [7:0] e;
    if (exp_rx.size() == 0) begin
      check({tag, "_sb_empty"}, o_rx_empty, 1);
    end else begin
      e = exp_rx.pop_front();
      check(tag, o_rx_data, e);
      i_rx_rd = 1'b1;
      wait_cyc(1);
      i_rx_rd = 1'b0;
    end
  endtask

  task automatic clear_err();
    i_clr_err = 1'b1;
    wait_cyc(1);
    i_clr_err = 1'b0;
    check("clr_overrun", o_rx_overrun, 0);
    check("clr_underrun", o_tx_underrun, 0);
  endtask

  task automatic set_mode(input logic cpol, input logic cpha, input logic lsb);
    i_cpol = cpol;
    i_cpha = cpha;
    i_lsb_first = lsb;
    i_sclk = cpol;
    m_cpha = cpha;
    m_lsb = lsb;
    wait_cyc(8);
  endtask

  task automatic ssn_low();
    i_ssn = 1'b0;
    wait_cyc(8);
  endtask

  task automatic ssn_high();
    wait_cyc(8);
    i_ssn = 1'b1;
    wait_cyc(8);
  endtask

  // Master side of one word; checks every MISO bit at the master's sample point.
  task automatic xfer(input logic [7:0] mo, input logic [7:0] exp_mi, input int nbits, input bit rd_sync);
    int idx;
    int prev;
    for (int i = 0; i < nbits; i++) begin
      idx = m_lsb ? i : 7 - i;
      prev = m_lsb ? i - 1 : 8 - i;
      if (!m_cpha) begin
        i_mosi = mo[idx];
        wait_cyc(8);
        i_sclk = ~i_sclk;
        check("miso_lead", o_miso, exp_mi[idx]);
        if (rd_sync && i == nbits - 1) begin
          wait_cyc(2);
          i_rx_rd = 1'b1;
          wait_cyc(1);
          i_rx_rd = 1'b0;
          wait_cyc(5);
        end else begin
          wait_cyc(8);
        end
        if (i < nbits - 1) check("miso_hold", o_miso, exp_mi[idx]);
        i_sclk = ~i_sclk;
      end else begin
        if (i > 0) check("miso_prev", o_miso, exp_mi[prev]);
        i_sclk = ~i_sclk;
        i_mosi = mo[idx];
        wait_cyc(8);
        i_sclk = ~i_sclk;
        check("miso_trail", o_miso, exp_mi[idx]);
        wait_cyc(8);
      end
    end
  endtask

  initial begin
    i_sys_rst = 1'b1; i_ssn = 1'b1; i_sclk = 1'b0; i_mosi = 1'b0;
    i_cpol = 1'b0; i_cpha = 1'b0; i_lsb_first = 1'b0;
    i_tx_data = '0; i_tx_wr = 1'b0; i_rx_rd = 1'b0; i_clr_err = 1'b0;
    wait_cyc(3);
    check_reset("rst");
    i_sys_rst = 1'b0;
    wait_cyc(8);
    check("idle_oe", o_miso_oe, 0);

    // Mode 0, MSB first
    tx_push(8'hA5);
    check("t1_tx_level_pre", o_tx_level, 1);
    set_mode(1'b0, 1'b0, 1'b0);
    base = done_cnt;
    ssn_low();
    check("t1_oe", o_miso_oe, 1);
    check("t1_tx_level", o_tx_level, 0);
    xfer(8'h3C, 8'hA5, 8, 1'b0);
    exp_rx.push_back(8'h3C);
    ssn_high();
    check("t1_oe_off", o_miso_oe, 0);
    check("t1_miso_off", o_miso, 0);
    check("t1_done", done_cnt - base, 1);
    check("t1_rx_level", o_rx_level, 1);
    check("t1_underrun", o_tx_underrun, 1);
    rx_pop_check("t1_rx");
    check("t1_rx_empty", o_rx_empty, 1);
    clear_err();

    // Mode 3, LSB first, two words with TX running dry
    tx_push(8'h12);
    set_mode(1'b1, 1'b1, 1'b1);
    ssn_low();
    xfer(8'h81, 8'h12, 8, 1'b0);
    xfer(8'h7E, 8'hFF, 8, 1'b0);
    exp_rx.push_back(8'h81);
    exp_rx.push_back(8'h7E);
    ssn_high();
    check("t2_underrun", o_tx_underrun, 1);
    check("t2_rx_level", o_rx_level, 2);
    rx_pop_check("t2_rx0");
    rx_pop_check("t2_rx1");
    clear_err();

    // Modes 1 and 2
    for (int k = 1; k <= 2; k++) begin
      logic [1:0] m;
      m = k[1:0];
      set_mode(m[1], m[0], 1'b0);
      tx_push(8'hC3);
      ssn_low();
      xfer(8'h5A, 8'hC3, 8, 1'b0);
      exp_rx.push_back(8'h5A);
      ssn_high();
      rx_pop_check("t3_rx");
    end
    clear_err();

    // RX overrun with a 4-deep FIFO, then simultaneous pop and push while full
    set_mode(1'b0, 1'b0, 1'b0);
    base = done_cnt;
    ssn_low();
    for (int w = 1; w <= 4; w++) begin
      logic [7:0] d;
      d = 8'(w * 17);
      xfer(d, 8'hFF, 8, 1'b0);
      exp_rx.push_back(d);
    end
    check("t4_level_full", o_rx_level, 4);
    check("t4_no_overrun", o_rx_overrun, 0);
    xfer(8'h55, 8'hFF, 8, 1'b0);
    check("t4_level_drop", o_rx_level, 4);
    check("t4_overrun", o_rx_overrun, 1);
    check("t4_done", done_cnt - base, 5);
    check("t4_head", o_rx_data, exp_rx[0]);
    clear_err();
    xfer(8'h66, 8'hFF, 8, 1'b1);
    void'(exp_rx.pop_front());
    exp_rx.push_back(8'h66);
    check("t4_level_rw", o_rx_level, 4);
    check("t4_overrun_rw", o_rx_overrun, 0);
    ssn_high();
    for (int w = 0; w < 4; w++) rx_pop_check("t4_rx");
    check("t4_rx_empty", o_rx_empty, 1);
    clear_err();

    // Partial frame discarded
    tx_push(8'h5B);
    tx_push(8'hE7);
    tx_push(8'h00);
    base = done_cnt;
    ssn_low();
    xfer(8'hF0, 8'h5B, 5, 1'b0);
    ssn_high();
    check("t5_partial_level", o_rx_level, 0);
    ssn_low();
    xfer(8'h99, 8'hE7, 8, 1'b0);
    exp_rx.push_back(8'h99);
    ssn_high();
    check("t5_rx_level", o_rx_level, 1);
    check("t5_done", done_cnt - base, 1);
    check("t5_overrun", o_rx_overrun, 0);
    check("t5_underrun", o_tx_underrun, 0);
    check("t5_tx_level", o_tx_level, 0);
    rx_pop_check("t5_rx");

    // Reset mid-word
    tx_push(8'h24);
    ssn_low();
    xfer(8'h42, 8'h24, 4, 1'b0);
    i_sys_rst = 1'b1;
    wait_cyc(2);
    check_reset("mid_rst");
    i_sys_rst = 1'b0;
    wait_cyc(8);
    check("t6_ignored_oe", o_miso_oe, 0);
    ssn_high();
    tx_push(8'h24);
    base = done_cnt;
    ssn_low();
    xfer(8'h42, 8'h24, 8, 1'b0);
    exp_rx.push_back(8'h42);
    ssn_high();
    check("t6_done", done_cnt - base, 1);
    check("t6_rx_level", o_rx_level, 1);
    rx_pop_check("t6_rx");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
